// File: rtl/cpu_memseq_if.sv
// cpu_memseq_if: external memory/mapper bus between cpu_memseq and the mapper.
//   mem_req   - request, level, held until ack or timeout
//   mem_addr  - address, stable while mem_req
//   mem_wdata - write data, stable while mem_req
//   mem_we    - write enable, stable while mem_req
//   mem_ack   - completion strobe from the mapper
//   mem_rdata - read data, valid with mem_ack
// master: the sequencer side; slave: the memory/mapper side.
interface cpu_memseq_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_wdata, mem_we,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_wdata, mem_we,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/cpu_memseq.sv
// cpu_memseq: performs one CPU bus cycle per cputick.
//   0x0000-0x1FFF -> internal 2 KiB work RAM (mirrored x4), fixed 2-edge latency.
//   others        -> external port via req/ack with a wait-cycle timeout.
// Ports:
//   clk, rst_n                     - clock, async active-low reset
//   cputick                        - one-cycle strobe starting a bus cycle
//   cpu_addr, cpu_wdata, cpu_we    - CPU cycle, sampled on cputick
//   cpu_rdata                      - read data / last bus value (open bus)
//   memdone                        - 1 = no access in flight
//   ext                            - external memory bus (master side)
//   overrun                        - sticky: cputick arrived while busy
//   timeout_err                    - sticky: an external access timed out
module cpu_memseq #(
    parameter int TIMEOUT = 255,
    parameter     RAMINIT = ""
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cputick,
    input  logic [15:0]        cpu_addr,
    input  logic [7:0]         cpu_wdata,
    input  logic               cpu_we,
    output logic [7:0]         cpu_rdata,
    output logic               memdone,
    cpu_memseq_if.master       ext,
    output logic               overrun,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        IRAM,
        EXT
    } state_t;

    // Abandon on the edge where the wait counter would reach TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [7:0]  rdata_q, rdata_n;
    logic        done_q, done_n;
    logic        req_q, req_n;
    logic [15:0] maddr_q, maddr_n;
    logic [7:0]  mwdata_q, mwdata_n;
    logic        mwe_q, mwe_n;
    logic        we_q, we_n;
    logic [7:0]  wdata_q, wdata_n;
    logic        overrun_q, overrun_n;
    logic        terr_q, terr_n;

    logic [7:0]  ram [0:2047];
    logic [7:0]  ram_q;
    logic        start;
    logic        is_iram;

    assign start   = cputick && (state == IDLE);
    assign is_iram = (cpu_addr[15:13] == 3'b000);

    // Work RAM is not reset. Access is issued on the edge entering IRAM,
    // directly from the CPU bus, so the result is ready one edge later.
    always_ff @(posedge clk) begin
        if (start && is_iram) begin
            if (cpu_we) begin
                ram[cpu_addr[10:0]] <= cpu_wdata;
            end else begin
                ram_q <= ram[cpu_addr[10:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b1;
            req_q     <= 1'b0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
            mwe_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            overrun_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rdata_q   <= rdata_n;
            done_q    <= done_n;
            req_q     <= req_n;
            maddr_q   <= maddr_n;
            mwdata_q  <= mwdata_n;
            mwe_q     <= mwe_n;
            we_q      <= we_n;
            wdata_q   <= wdata_n;
            overrun_q <= overrun_n;
            terr_q    <= terr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rdata_n   = rdata_q;
        done_n    = done_q;
        req_n     = req_q;
        maddr_n   = maddr_q;
        mwdata_n  = mwdata_q;
        mwe_n     = mwe_q;
        we_n      = we_q;
        wdata_n   = wdata_q;
        overrun_n = overrun_q;
        terr_n    = terr_q;

        case (state)
            IDLE: begin
                if (cputick) begin
                    we_n    = cpu_we;
                    wdata_n = cpu_wdata;
                    done_n  = 1'b0;
                    if (is_iram) begin
                        state_n = IRAM;
                    end else begin
                        state_n  = EXT;
                        req_n    = 1'b1;
                        maddr_n  = cpu_addr;
                        mwdata_n = cpu_wdata;
                        mwe_n    = cpu_we;
                        cnt_n    = '0;
                    end
                end
            end
            IRAM: begin
                rdata_n = we_q ? wdata_q : ram_q;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            EXT: begin
                // Ack is checked first so an ack on the timeout edge wins.
                if (ext.mem_ack) begin
                    rdata_n = we_q ? wdata_q : ext.mem_rdata;
                    req_n   = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (cnt == TO_LAST) begin
                    req_n   = 1'b0;
                    done_n  = 1'b1;
                    terr_n  = 1'b1;
                    state_n = IDLE;
                end else if (cnt != '1) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (cputick && (state != IDLE)) begin
            overrun_n = 1'b1;
        end
    end

    assign cpu_rdata     = rdata_q;
    assign memdone       = done_q;
    assign overrun       = overrun_q;
    assign timeout_err   = terr_q;
    assign ext.mem_req   = req_q;
    assign ext.mem_addr  = maddr_q;
    assign ext.mem_wdata = mwdata_q;
    assign ext.mem_we    = mwe_q;

endmodule

// File: tb/tb_cpu_memseq.sv
// tb_cpu_memseq: scenario tasks for cpu_memseq (TIMEOUT=4). Expected read data
// is queued when a cycle is issued and compared when memdone returns.
module tb_cpu_memseq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cputick = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_rdata;
    logic        memdone;
    logic        overrun;
    logic        timeout_err;

    cpu_memseq_if bus ();

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp;

    always #5 clk = ~clk;

    cpu_memseq #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cputick     (cputick),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_we      (cpu_we),
        .cpu_rdata   (cpu_rdata),
        .memdone     (memdone),
        .ext         (bus),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [7:0] d, input logic we);
        cputick   = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = we;
        @(negedge clk);
        cputick   = 1'b0;
    endtask

    task automatic test_reset;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (memdone !== 1'b1) begin miscompares++; $display("FAIL rst_memdone got %b want 1", memdone); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got %b want 0", bus.mem_req); end
        vectors++; if (cpu_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_rdata got %h want 00", cpu_rdata); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rst_overrun got %b want 0", overrun); end
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_timeout_err got %b want 0", timeout_err); end
        vectors++; if (bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 8'h00 || bus.mem_we !== 1'b0) begin
            miscompares++; $display("FAIL rst_mem_bus got %h/%h/%b want 0000/00/0", bus.mem_addr, bus.mem_wdata, bus.mem_we);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_iram;
        logic req_seen;
        req_seen = 1'b0;
        exp_q.push_back(8'hA5);
        issue(16'h0123, 8'hA5, 1'b1);
        req_seen |= bus.mem_req;
        vectors++; if (memdone !== 1'b0) begin miscompares++; $display("FAIL iram_wr_busy got %b want 0", memdone); end
        @(negedge clk);
        req_seen |= bus.mem_req;
        vectors++; if (memdone !== 1'b1) begin miscompares++; $display("FAIL iram_wr_done got %b want 1", memdone); end
        exp = exp_q.pop_front();
        vectors++; if (cpu_rdata !== exp) begin miscompares++; $display("FAIL iram_wr_rdata got %h want %h", cpu_rdata, exp); end

        exp_q.push_back(8'hA5);
        issue(16'h1923, 8'h00, 1'b0);
        req_seen |= bus.mem_req;
        vectors++; if (memdone !== 1'b0) begin miscompares++; $display("FAIL iram_rd_busy got %b want 0", memdone); end
        @(negedge clk);
        req_seen |= bus.mem_req;
        vectors++; if (memdone !== 1'b1) begin miscompares++; $display("FAIL iram_rd_done got %b want 1", memdone); end
        exp = exp_q.pop_front();
        vectors++; if (cpu_rdata !== exp) begin miscompares++; $display("FAIL iram_mirror_rdata got %h want %h", cpu_rdata, exp); end
        vectors++; if (req_seen !== 1'b0) begin miscompares++; $display("FAIL iram_no_req got %b want 0", req_seen); end
    endtask

    task automatic test_ext_read;
        int req_cycles;
        req_cycles = 0;
        exp_q.push_back(8'h3C);
        issue(16'h8000, 8'hFF, 1'b0);
        vectors++; if (memdone !== 1'b0) begin miscompares++; $display("FAIL extrd_busy got %b want 0", memdone); end
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_req === 1'b1) req_cycles++;
            vectors++; if (bus.mem_addr !== 16'h8000 || bus.mem_we !== 1'b0) begin
                miscompares++; $display("FAIL extrd_bus got %h/%b want 8000/0", bus.mem_addr, bus.mem_we);
            end
            if (i == 3) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 8'h3C;
            end
            @(negedge clk);
        end
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        vectors++; if (req_cycles != 4) begin miscompares++; $display("FAIL extrd_req_cycles got %0d want 4", req_cycles); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL extrd_req_drop got %b want 0", bus.mem_req); end
        vectors++; if (memdone !== 1'b1) begin miscompares++; $display("FAIL extrd_done got %b want 1", memdone); end
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL extrd_ack_wins got %b want 0", timeout_err); end
        exp = exp_q.pop_front();
        vectors++; if (cpu_rdata !== exp) begin miscompares++; $display("FAIL extrd_rdata got %h want %h", cpu_rdata, exp); end
    endtask

    task automatic test_ext_write;
        exp_q.push_back(8'h02);
        issue(16'h4014, 8'h02, 1'b1);
        vectors++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 8'h02 || bus.mem_addr !== 16'h4014) begin
            miscompares++; $display("FAIL extwr_bus got %b/%b/%h/%h want 1/1/02/4014", bus.mem_req, bus.mem_we, bus.mem_wdata, bus.mem_addr);
        end
        vectors++; if (memdone !== 1'b0) begin miscompares++; $display("FAIL extwr_busy got %b want 0", memdone); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'hEE;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        vectors++; if (memdone !== 1'b1) begin miscompares++; $display("FAIL extwr_done got %b want 1", memdone); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL extwr_req_drop got %b want 0", bus.mem_req); end
        exp = exp_q.pop_front();
        vectors++; if (cpu_rdata !== exp) begin miscompares++; $display("FAIL extwr_rdata got %h want %h", cpu_rdata, exp); end
    endtask

    task automatic test_timeout;
        int req_cycles;
        int waited;
        // 0x2000 is the first external address.
        exp_q.push_back(8'h3C);
        issue(16'h2000, 8'h00, 1'b0);
        vectors++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h2000) begin
            miscompares++; $display("FAIL bound_2000_ext got %b/%h want 1/2000", bus.mem_req, bus.mem_addr);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h3C;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        exp = exp_q.pop_front();
        vectors++; if (cpu_rdata !== exp) begin miscompares++; $display("FAIL bound_2000_rdata got %h want %h", cpu_rdata, exp); end

        exp_q.push_back(8'h3C);
        issue(16'h5000, 8'h00, 1'b0);
        req_cycles = 0;
        waited = 0;
        while (memdone !== 1'b1 && waited < 20) begin
            if (bus.mem_req === 1'b1) req_cycles++;
            @(negedge clk);
            waited++;
        end
        vectors++; if (waited >= 20) begin miscompares++; $display("FAIL to_wait got %0d cycles want <20", waited); end
        vectors++; if (req_cycles != 4) begin miscompares++; $display("FAIL to_req_cycles got %0d want 4", req_cycles); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL to_req_drop got %b want 0", bus.mem_req); end
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_err got %b want 1", timeout_err); end
        exp = exp_q.pop_front();
        vectors++; if (cpu_rdata !== exp) begin miscompares++; $display("FAIL to_open_bus got %h want %h", cpu_rdata, exp); end
    endtask

    task automatic test_overrun;
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_before got %b want 0", overrun); end
        exp_q.push_back(8'h77);
        issue(16'hC000, 8'h00, 1'b0);
        issue(16'hD000, 8'h11, 1'b1);
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set got %b want 1", overrun); end
        vectors++; if (bus.mem_addr !== 16'hC000 || bus.mem_req !== 1'b1) begin
            miscompares++; $display("FAIL ovr_bus got %h/%b want C000/1", bus.mem_addr, bus.mem_req);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h77;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        vectors++; if (memdone !== 1'b1) begin miscompares++; $display("FAIL ovr_first_done got %b want 1", memdone); end
        exp = exp_q.pop_front();
        vectors++; if (cpu_rdata !== exp) begin miscompares++; $display("FAIL ovr_first_rdata got %h want %h", cpu_rdata, exp); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 16'hC000 || memdone !== 1'b1) begin
                miscompares++; $display("FAIL ovr_no_second got %b/%h/%b want 0/C000/1", bus.mem_req, bus.mem_addr, memdone);
            end
        end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid;
        issue(16'h6000, 8'h00, 1'b0);
        vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL rmid_req_up got %b want 1", bus.mem_req); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rmid_req_async got %b want 0", bus.mem_req); end
        vectors++; if (memdone !== 1'b1 || cpu_rdata !== 8'h00) begin
            miscompares++; $display("FAIL rmid_state got %b/%h want 1/00", memdone, cpu_rdata);
        end
        vectors++; if (overrun !== 1'b0 || timeout_err !== 1'b0) begin
            miscompares++; $display("FAIL rmid_sticky_clr got %b/%b want 0/0", overrun, timeout_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'hAB;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        vectors++; if (bus.mem_req !== 1'b0 || memdone !== 1'b1 || cpu_rdata !== 8'h00) begin
            miscompares++; $display("FAIL rmid_late_ack got %b/%b/%h want 0/1/00", bus.mem_req, memdone, cpu_rdata);
        end
        // A fresh access must be accepted from IDLE; work RAM kept its data.
        exp_q.push_back(8'hA5);
        issue(16'h0123, 8'h00, 1'b0);
        @(negedge clk);
        vectors++; if (memdone !== 1'b1) begin miscompares++; $display("FAIL rmid_idle_done got %b want 1", memdone); end
        exp = exp_q.pop_front();
        vectors++; if (cpu_rdata !== exp) begin miscompares++; $display("FAIL rmid_ram_kept got %h want %h", cpu_rdata, exp); end
    endtask

    initial begin
        test_reset();
        test_iram();
        test_ext_read();
        test_ext_write();
        test_timeout();
        test_overrun();
        test_reset_mid();
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
